// File: rtl/usb_fs_rx_decoder.sv
// Full-speed USB receive front end: input sync, 4x DPLL, NRZI decode, unstuffing, UTMI rx side.
// Define USB_RX_GLITCH_FILTER_EN to add a 2-sample glitch filter after the synchronizers.
module usb_fs_rx_decoder #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned BABBLE_BYTES = 1030
) (
   input  logic       clk_i,
   input  logic       n_rst_i,
   input  logic       rx_en_i,
   input  logic       usb_rx_rcv_i,
   input  logic       usb_rx_dp_i,
   input  logic       usb_rx_dn_i,
   output logic [7:0] utmi_data_in_o,
   output logic       utmi_rxvalid_o,
   output logic       utmi_rxactive_o,
   output logic       utmi_rxerror_o,
   output logic [1:0] utmi_linestate_o
);

   localparam int unsigned BCW = $clog2(BABBLE_BYTES + 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SYNC   = 3'd1;
   localparam logic [2:0] ST_ACTIVE = 3'd2;
   localparam logic [2:0] ST_EOP    = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;

   logic [SYNC_STAGES-1:0] rcv_sync_q, dp_sync_q, dn_sync_q;
   logic [2:0]             raw_s, filt;
   logic                   rcv_l, dp_l, dn_l, se0;

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         rcv_sync_q <= '1;
         dp_sync_q  <= '0;
         dn_sync_q  <= '0;
      end else begin
         rcv_sync_q <= {rcv_sync_q[SYNC_STAGES-2:0], usb_rx_rcv_i};
         dp_sync_q  <= {dp_sync_q[SYNC_STAGES-2:0], usb_rx_dp_i};
         dn_sync_q  <= {dn_sync_q[SYNC_STAGES-2:0], usb_rx_dn_i};
      end
   end

   assign raw_s = {rcv_sync_q[SYNC_STAGES-1], dp_sync_q[SYNC_STAGES-1], dn_sync_q[SYNC_STAGES-1]};

`ifdef USB_RX_GLITCH_FILTER_EN
   logic [2:0] prev_q, filt_q;

   // A bit follows the input only once two consecutive samples agree; otherwise it holds.
   assign filt = ((raw_s ^ prev_q) & filt_q) | (~(raw_s ^ prev_q) & raw_s);

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         prev_q <= 3'b100;
         filt_q <= 3'b100;
      end else begin
         prev_q <= raw_s;
         filt_q <= filt;
      end
   end
`else
   assign filt = raw_s;
`endif

   assign rcv_l = filt[2];
   assign dp_l  = filt[1];
   assign dn_l  = filt[0];
   assign se0   = ~dp_l & ~dn_l;
   assign utmi_linestate_o = {dn_l, dp_l};

   logic [2:0]     state_q, state_d;
   logic [1:0]     phase_q, phase_d;
   logic           rcv_prev_q;
   logic           prev_lvl_q, prev_lvl_d;
   logic [2:0]     ones_q, ones_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [6:0]     shift_q, shift_d;
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]     data_q, data_d;
   logic           rxvalid_q, rxvalid_d;
   logic           rxerror_q, rxerror_d;
   logic           rxactive_q, rxactive_d;
   logic           flag_q, flag_d;
   logic           sample, nrzi_bit;

   assign sample   = (phase_q == 2'd1);
   assign nrzi_bit = (rcv_l == prev_lvl_q);

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         rcv_prev_q <= 1'b1;
         prev_lvl_q <= 1'b1;
         ones_q     <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         data_q     <= '0;
         rxvalid_q  <= 1'b0;
         rxerror_q  <= 1'b0;
         rxactive_q <= 1'b0;
         flag_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         rcv_prev_q <= rcv_l;
         prev_lvl_q <= prev_lvl_d;
         ones_q     <= ones_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         data_q     <= data_d;
         rxvalid_q  <= rxvalid_d;
         rxerror_q  <= rxerror_d;
         rxactive_q <= rxactive_d;
         flag_q     <= flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = (rcv_l != rcv_prev_q) ? 2'd0 : phase_q + 2'd1;
      prev_lvl_d = (sample && !se0) ? rcv_l : prev_lvl_q;
      ones_d     = ones_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      data_d     = data_q;
      rxvalid_d  = 1'b0;
      rxerror_d  = 1'b0;
      rxactive_d = rxactive_q;
      flag_d     = flag_q;

      case (state_q)
         ST_IDLE: begin
            if (sample && !se0 && !rcv_l) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (sample) begin
               if (se0) begin
                  state_d = ST_IDLE;
               end else if (nrzi_bit && !rcv_l) begin
                  state_d    = ST_ACTIVE;
                  rxactive_d = 1'b1;
                  ones_d     = '0;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
               end else if (nrzi_bit) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_ACTIVE: begin
            if (sample) begin
               if (se0) begin
                  state_d = ST_EOP;
                  flag_d  = (bit_cnt_q != 3'd0);
               end else if (ones_q == 3'd6) begin
                  // Stuffed position: a 0 is dropped, a 1 is a stuff error.
                  ones_d = '0;
                  if (nrzi_bit) begin
                     state_d   = ST_ERROR;
                     rxerror_d = 1'b1;
                     flag_d    = 1'b0;
                  end
               end else begin
                  shift_d   = {nrzi_bit, shift_q[6:1]};
                  ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (byte_cnt_q == BCW'(BABBLE_BYTES)) begin
                        state_d   = ST_ERROR;
                        rxerror_d = 1'b1;
                        flag_d    = 1'b0;
                     end else begin
                        data_d     = {nrzi_bit, shift_q};
                        rxvalid_d  = 1'b1;
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                     end
                  end
               end
            end
         end
         ST_EOP: begin
            if (sample && !se0 && rcv_l) begin
               state_d    = ST_IDLE;
               rxactive_d = 1'b0;
               rxerror_d  = flag_q;
               flag_d     = 1'b0;
            end
         end
         ST_ERROR: begin
            if (sample) begin
               if (se0) begin
                  flag_d = 1'b1;
               end else if (flag_q && rcv_l) begin
                  state_d    = ST_IDLE;
                  rxactive_d = 1'b0;
                  flag_d     = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rx_en_i) begin
         state_d    = ST_IDLE;
         phase_d    = '0;
         prev_lvl_d = 1'b1;
         ones_d     = '0;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         rxvalid_d  = 1'b0;
         rxerror_d  = 1'b0;
         rxactive_d = 1'b0;
         flag_d     = 1'b0;
      end
   end

   assign utmi_data_in_o  = data_q;
   assign utmi_rxvalid_o  = rxvalid_q;
   assign utmi_rxerror_o  = rxerror_q;
   assign utmi_rxactive_o = rxactive_q;

endmodule
